// File: rtl/calc_rr_dispatch.sv
// Round-robin dispatcher between four port hold registers and the two calc1 ALUs.
// Each port owns one command slot; ALU1 takes cmd 1-3, ALU2 takes cmd 4-15.
module calc_rr_dispatch #(
    parameter int TIMEOUT = 16
) (
    input  logic       c_clk,
    input  logic       reset,
    input  logic [3:0] hold1_cmd,
    input  logic [3:0] hold2_cmd,
    input  logic [3:0] hold3_cmd,
    input  logic [3:0] hold4_cmd,
    input  logic       alu1_done,
    input  logic       alu2_done,
    output logic       alu1_in_vld,
    output logic       alu2_in_vld,
    output logic [3:0] alu1_in_cmd,
    output logic [3:0] alu2_in_cmd,
    output logic [1:0] alu1_in_req_id,
    output logic [1:0] alu2_in_req_id,
    output logic [3:0] port_busy,
    output logic [3:0] port_err,
    output logic [1:0] alu_timeout_err
);

    typedef enum logic [1:0] {
        SLOT_EMPTY    = 2'd0,
        SLOT_PENDING  = 2'd1,
        SLOT_INFLIGHT = 2'd2
    } slot_state_t;

    typedef enum logic {
        ALU_IDLE = 1'b0,
        ALU_WAIT = 1'b1
    } alu_state_t;

    // Counter value on the edge that must release a hung ALU.
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    logic [3:0]  hold_cmd   [4];
    logic [1:0]  alu_done;

    slot_state_t slot_state [4];
    slot_state_t slot_next  [4];
    logic [3:0]  slot_cmd   [4];
    logic [3:0]  capture_en;
    logic [3:0]  drop;
    logic [3:0]  freed;
    logic [3:0]  issued;
    logic [3:0]  busy_r;
    logic [3:0]  perr_r;

    alu_state_t  alu_state  [2];
    logic [1:0]  last_ptr   [2];
    logic [7:0]  wait_cnt   [2];
    logic        in_vld     [2];
    logic [3:0]  in_cmd     [2];
    logic [1:0]  in_id      [2];
    logic [1:0]  terr_r;

    logic [3:0]  elig       [2];
    logic        grant_vld  [2];
    logic [1:0]  grant_id   [2];
    logic        release_now[2];
    logic        timeout_hit[2];

    assign hold_cmd[0] = hold1_cmd;
    assign hold_cmd[1] = hold2_cmd;
    assign hold_cmd[2] = hold3_cmd;
    assign hold_cmd[3] = hold4_cmd;
    assign alu_done    = {alu2_done, alu1_done};

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            elig[0][n] = (slot_state[n] == SLOT_PENDING) && (slot_cmd[n] <= 4'd3);
            elig[1][n] = (slot_state[n] == SLOT_PENDING) && (slot_cmd[n] >= 4'd4);
        end

        for (int a = 0; a < 2; a++) begin
            grant_vld[a]   = 1'b0;
            grant_id[a]    = 2'd0;
            release_now[a] = (alu_state[a] == ALU_WAIT) && (alu_done[a] || wait_cnt[a] == CNT_LIMIT);
            timeout_hit[a] = (alu_state[a] == ALU_WAIT) && !alu_done[a] && (wait_cnt[a] == CNT_LIMIT);
            // Search starts just past the last grant so every port gets a turn.
            for (int k = 1; k <= 4; k++) begin
                if (!grant_vld[a] && elig[a][last_ptr[a] + 2'(k)]) begin
                    grant_vld[a] = 1'b1;
                    grant_id[a]  = last_ptr[a] + 2'(k);
                end
            end
        end

        for (int n = 0; n < 4; n++) begin
            freed[n]  = 1'b0;
            issued[n] = 1'b0;
            for (int a = 0; a < 2; a++) begin
                if (release_now[a] && in_id[a] == 2'(n))
                    freed[n] = 1'b1;
                if (alu_state[a] == ALU_IDLE && grant_vld[a] && grant_id[a] == 2'(n))
                    issued[n] = 1'b1;
            end
        end

        for (int n = 0; n < 4; n++) begin
            slot_next[n]  = slot_state[n];
            capture_en[n] = 1'b0;
            drop[n]       = 1'b0;
            if (hold_cmd[n] != 4'd0 && (slot_state[n] == SLOT_EMPTY || freed[n])) begin
                slot_next[n]  = SLOT_PENDING;
                capture_en[n] = 1'b1;
            end else begin
                drop[n] = (hold_cmd[n] != 4'd0);
                if (freed[n])
                    slot_next[n] = SLOT_EMPTY;
                else if (issued[n])
                    slot_next[n] = SLOT_INFLIGHT;
            end
        end
    end

    // NOTE: the command payload is qualified by slot_state, so it carries no reset.
    always_ff @(posedge c_clk) begin
        for (int n = 0; n < 4; n++) begin
            if (capture_en[n])
                slot_cmd[n] <= hold_cmd[n];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so later defaults never race earlier reads.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int n = 0; n < 4; n++)
                slot_state[n] <= SLOT_EMPTY;
            busy_r <= '0;
            perr_r <= '0;
            terr_r <= '0;
            for (int a = 0; a < 2; a++) begin
                alu_state[a] <= ALU_IDLE;
                last_ptr[a]  <= 2'd3;
                wait_cnt[a]  <= '0;
                in_vld[a]    <= 1'b0;
                in_cmd[a]    <= '0;
                in_id[a]     <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                slot_state[n] <= slot_next[n];
                busy_r[n]     <= (slot_next[n] != SLOT_EMPTY);
                if (drop[n])
                    perr_r[n] <= 1'b1;
            end

            for (int a = 0; a < 2; a++) begin
                in_vld[a] <= 1'b0;
                case (alu_state[a])
                    ALU_IDLE: begin
                        if (grant_vld[a]) begin
                            in_vld[a]    <= 1'b1;
                            in_cmd[a]    <= slot_cmd[grant_id[a]];
                            in_id[a]     <= grant_id[a];
                            last_ptr[a]  <= grant_id[a];
                            wait_cnt[a]  <= '0;
                            alu_state[a] <= ALU_WAIT;
                        end
                    end
                    ALU_WAIT: begin
                        if (release_now[a]) begin
                            in_cmd[a]    <= '0;
                            in_id[a]     <= '0;
                            wait_cnt[a]  <= '0;
                            alu_state[a] <= ALU_IDLE;
                            if (timeout_hit[a])
                                terr_r[a] <= 1'b1;
                        end else begin
                            wait_cnt[a] <= wait_cnt[a] + 8'd1;
                        end
                    end
                    default: alu_state[a] <= ALU_IDLE;
                endcase
            end
        end
    end

    assign alu1_in_vld     = in_vld[0];
    assign alu2_in_vld     = in_vld[1];
    assign alu1_in_cmd     = in_cmd[0];
    assign alu2_in_cmd     = in_cmd[1];
    assign alu1_in_req_id  = in_id[0];
    assign alu2_in_req_id  = in_id[1];
    assign port_busy       = busy_r;
    assign port_err        = perr_r;
    assign alu_timeout_err = terr_r;

endmodule

// File: tb/tb_calc_rr_dispatch.sv
// Scoreboard bench for calc_rr_dispatch: a slot/age reference model predicts issues and
// status every edge; a negedge monitor compares the DUT against it.
module tb_calc_rr_dispatch;

    localparam int TIMEOUT = 16;

    logic       c_clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] hold1_cmd = '0, hold2_cmd = '0, hold3_cmd = '0, hold4_cmd = '0;
    logic       alu1_done = 1'b0, alu2_done = 1'b0;
    logic       alu1_in_vld, alu2_in_vld;
    logic [3:0] alu1_in_cmd, alu2_in_cmd;
    logic [1:0] alu1_in_req_id, alu2_in_req_id;
    logic [3:0] port_busy, port_err;
    logic [1:0] alu_timeout_err;

    calc_rr_dispatch #(.TIMEOUT(TIMEOUT)) dut (
        .c_clk           (c_clk),
        .reset           (reset),
        .hold1_cmd       (hold1_cmd),
        .hold2_cmd       (hold2_cmd),
        .hold3_cmd       (hold3_cmd),
        .hold4_cmd       (hold4_cmd),
        .alu1_done       (alu1_done),
        .alu2_done       (alu2_done),
        .alu1_in_vld     (alu1_in_vld),
        .alu2_in_vld     (alu2_in_vld),
        .alu1_in_cmd     (alu1_in_cmd),
        .alu2_in_cmd     (alu2_in_cmd),
        .alu1_in_req_id  (alu1_in_req_id),
        .alu2_in_req_id  (alu2_in_req_id),
        .port_busy       (port_busy),
        .port_err        (port_err),
        .alu_timeout_err (alu_timeout_err)
    );

    always #5 c_clk = ~c_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot occupancy 0=empty 1=waiting 2=at ALU; age = cycles since issue.
    typedef struct {
        int cmd;
        int id;
    } issue_t;

    issue_t q0[$];
    issue_t q1[$];
    int     m_state[4];
    int     m_cmd[4];
    bit     m_wait[2];
    int     m_ptr[2], m_age[2], m_owner[2], m_out_cmd[2], m_out_id[2];
    bit     m_exp_vld[2];
    bit [3:0] m_perr;
    bit [1:0] m_terr;
    bit     m_ready = 1'b0;
    int     hc[4];
    bit     dn[2];
    int     old_state[4];
    bit     freed[4];

    always @(posedge c_clk) begin
        hc[0] = int'(hold1_cmd); hc[1] = int'(hold2_cmd);
        hc[2] = int'(hold3_cmd); hc[3] = int'(hold4_cmd);
        dn[0] = alu1_done; dn[1] = alu2_done;
        m_exp_vld[0] = 1'b0; m_exp_vld[1] = 1'b0;
        if (reset) begin
            m_ready = 1'b1;
            for (int n = 0; n < 4; n++) begin m_state[n] = 0; m_cmd[n] = 0; end
            for (int a = 0; a < 2; a++) begin
                m_wait[a] = 1'b0; m_ptr[a] = 3; m_age[a] = 0; m_owner[a] = 0;
                m_out_cmd[a] = 0; m_out_id[a] = 0;
            end
            m_perr = '0; m_terr = '0;
            q0.delete(); q1.delete();
        end else if (m_ready) begin
            for (int n = 0; n < 4; n++) begin old_state[n] = m_state[n]; freed[n] = 1'b0; end
            for (int a = 0; a < 2; a++) begin
                if (m_wait[a]) begin
                    m_age[a]++;
                    if (dn[a] || m_age[a] == TIMEOUT) begin
                        if (!dn[a]) m_terr[a] = 1'b1;
                        freed[m_owner[a]] = 1'b1;
                        m_wait[a] = 1'b0; m_out_cmd[a] = 0; m_out_id[a] = 0;
                    end
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        int p;
                        p = (m_ptr[a] + k) % 4;
                        if (old_state[p] == 1 && ((m_cmd[p] >= 4) ? 1 : 0) == a) begin
                            issue_t it;
                            it.cmd = m_cmd[p]; it.id = p;
                            if (a == 0) q0.push_back(it); else q1.push_back(it);
                            m_state[p] = 2; m_ptr[a] = p; m_owner[a] = p; m_age[a] = 0;
                            m_wait[a] = 1'b1; m_out_cmd[a] = m_cmd[p]; m_out_id[a] = p;
                            m_exp_vld[a] = 1'b1;
                            break;
                        end
                    end
                end
            end
            for (int n = 0; n < 4; n++) begin
                if (hc[n] != 0) begin
                    if (old_state[n] == 0 || freed[n]) begin
                        m_state[n] = 1; m_cmd[n] = hc[n];
                    end else begin
                        m_perr[n] = 1'b1;
                    end
                end else if (freed[n]) begin
                    m_state[n] = 0;
                end
            end
        end
    end

    // Monitor: pops the expected issue whenever the DUT strobes, and tracks status every cycle.
    always @(negedge c_clk) begin
        if (m_ready) begin
            for (int a = 0; a < 2; a++) begin
                logic dv; int dc; int di; issue_t e;
                dv = (a == 0) ? alu1_in_vld : alu2_in_vld;
                dc = int'((a == 0) ? alu1_in_cmd : alu2_in_cmd);
                di = int'((a == 0) ? alu1_in_req_id : alu2_in_req_id);
                check($sformatf("alu%0d_vld", a + 1), int'(dv), int'(m_exp_vld[a]));
                if (dv === 1'b1) begin
                    check($sformatf("alu%0d_issue_expected", a + 1),
                          int'(((a == 0) ? q0.size() : q1.size()) > 0), 1);
                    if (((a == 0) ? q0.size() : q1.size()) > 0) begin
                        e = (a == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("alu%0d_issue_cmd", a + 1), dc, e.cmd);
                        check($sformatf("alu%0d_issue_id", a + 1), di, e.id);
                    end
                end
                check($sformatf("alu%0d_hold_cmd", a + 1), dc, m_out_cmd[a]);
                check($sformatf("alu%0d_hold_id", a + 1), di, m_out_id[a]);
            end
            check("port_busy", int'(port_busy),
                  int'({m_state[3] != 0, m_state[2] != 0, m_state[1] != 0, m_state[0] != 0}));
            check("port_err", int'(port_err), int'(m_perr));
            check("alu_timeout_err", int'(alu_timeout_err), int'(m_terr));
        end
    end

    task automatic step();
        @(negedge c_clk);
        hold1_cmd = '0; hold2_cmd = '0; hold3_cmd = '0; hold4_cmd = '0;
        alu1_done = 1'b0; alu2_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_vld(input int a, input int budget);
        int n = 0;
        while (((a == 0) ? alu1_in_vld : alu2_in_vld) !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check($sformatf("alu%0d_strobe_within_budget", a + 1),
              int'(((a == 0) ? alu1_in_vld : alu2_in_vld) === 1'b1), 1);
    endtask

    initial begin
        do_reset();
        check("reset_outputs_zero",
              int'({alu1_in_vld, alu2_in_vld, alu1_in_cmd, alu2_in_cmd, alu1_in_req_id,
                    alu2_in_req_id, port_busy, port_err, alu_timeout_err}), 0);

        // Single request on port 1, done three cycles after the strobe.
        hold1_cmd = 4'd1;
        step();
        check("t1_busy_after_capture", int'(port_busy), 1);
        step();
        check("t1_strobe_two_cycles", int'(alu1_in_vld), 1);
        check("t1_cmd", int'(alu1_in_cmd), 1);
        check("t1_id", int'(alu1_in_req_id), 0);
        step(); step();
        alu1_done = 1'b1;
        step();
        check("t1_busy_released", int'(port_busy), 0);

        // All four ports at once on ALU1: ids 0..3 in order.
        do_reset();
        hold1_cmd = 4'd2; hold2_cmd = 4'd2; hold3_cmd = 4'd2; hold4_cmd = 4'd2;
        step();
        for (int i = 0; i < 4; i++) begin
            wait_vld(0, 8);
            check("t2_rotation_id", int'(alu1_in_req_id), i);
            step();
            alu1_done = 1'b1;
            step();
        end
        check("t2_no_port_err", int'(port_err), 0);

        // Both ALUs issue on the same edge.
        do_reset();
        hold2_cmd = 4'd1; hold3_cmd = 4'd5;
        step(); step();
        check("t3_both_vld", int'({alu2_in_vld, alu1_in_vld}), 3);
        check("t3_alu1_id", int'(alu1_in_req_id), 1);
        check("t3_alu2_id", int'(alu2_in_req_id), 2);
        check("t3_alu2_cmd", int'(alu2_in_cmd), 5);
        alu1_done = 1'b1;
        step(); step();
        alu2_done = 1'b1;
        step();
        check("t3_all_free", int'(port_busy), 0);

        // Drop while in flight, capture on the done edge.
        do_reset();
        hold1_cmd = 4'd4;
        step(); step();
        hold1_cmd = 4'd6;
        step();
        check("t4_port_err", int'(port_err), 1);
        hold1_cmd = 4'd7; alu2_done = 1'b1;
        step();
        check("t4_busy_kept", int'(port_busy), 1);
        wait_vld(1, 4);
        check("t4_third_cmd", int'(alu2_in_cmd), 7);
        alu2_done = 1'b1;
        step();

        // Timeout on ALU2, then a done landing exactly on the timeout edge.
        do_reset();
        hold3_cmd = 4'd5;
        step();
        wait_vld(1, 4);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        check("t5_still_busy", int'(port_busy), 4);
        step();
        check("t5_released", int'(port_busy), 0);
        check("t5_timeout_err", int'(alu_timeout_err), 2);
        do_reset();
        hold3_cmd = 4'd5;
        step();
        wait_vld(1, 4);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        alu2_done = 1'b1;
        step();
        check("t5_done_wins", int'(alu_timeout_err), 0);

        // Reset in the middle of a WAIT with pending slots.
        do_reset();
        hold1_cmd = 4'd1; hold2_cmd = 4'd1; hold3_cmd = 4'd1;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_outputs_zero",
              int'({alu1_in_vld, alu2_in_vld, alu1_in_cmd, alu2_in_cmd, alu1_in_req_id,
                    alu2_in_req_id, port_busy, port_err, alu_timeout_err}), 0);
        alu1_done = 1'b1;
        step();
        hold1_cmd = 4'd3;
        step();
        wait_vld(0, 4);
        check("t6_restart_id", int'(alu1_in_req_id), 0);
        alu1_done = 1'b1;
        step();

        // Random traffic: busy done phase, then a sparse done phase that hits timeouts.
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 1500; c++) begin
                hold1_cmd = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                hold2_cmd = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                hold3_cmd = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                hold4_cmd = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                alu1_done = ($urandom_range(0, (phase == 0) ? 3 : 30) == 0);
                alu2_done = ($urandom_range(0, (phase == 0) ? 3 : 30) == 0);
                reset     = ($urandom_range(0, 400) == 0);
                step();
                reset = 1'b0;
            end
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
